// File: rtl/gpio_pkg.sv
// Shared register map and bus helpers for the GPIO interrupt peripheral.
// Offset 0x2C (DEBOUNCE) is decoded only in builds that define GPIO_DEBOUNCE_EN.
package gpio_pkg;

  localparam logic [11:0] OFF_OE       = 12'h000;
  localparam logic [11:0] OFF_OUT      = 12'h004;
  localparam logic [11:0] OFF_OUT_SET  = 12'h008;
  localparam logic [11:0] OFF_OUT_CLR  = 12'h00C;
  localparam logic [11:0] OFF_OUT_TGL  = 12'h010;
  localparam logic [11:0] OFF_IN       = 12'h014;
  localparam logic [11:0] OFF_IRQ_EN   = 12'h018;
  localparam logic [11:0] OFF_IRQ_EDGE = 12'h01C;
  localparam logic [11:0] OFF_IRQ_POL  = 12'h020;
  localparam logic [11:0] OFF_IRQ_BOTH = 12'h024;
  localparam logic [11:0] OFF_IRQ_STAT = 12'h028;
  localparam logic [11:0] OFF_DEBOUNCE = 12'h02C;

  localparam logic [31:0] UNMAPPED_READ = 32'hFFFF_FFFF;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// Per-pin input conditioning: 2-flop synchroniser, optional debounce, and a one-cycle delay for edge detection.
// The debounce stage exists only when GPIO_DEBOUNCE_EN is defined; otherwise the filtered value is the synchronised input.
module gpio_pin_filter
  import gpio_pkg::*;
#(
  parameter int IO_COUNT   = 16,
  parameter int DEBOUNCE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IO_COUNT-1:0]   pin_in,
  input  logic [DEBOUNCE_W-1:0] debounce,
  output logic [IO_COUNT-1:0]   filt,
  output logic [IO_COUNT-1:0]   rise,
  output logic [IO_COUNT-1:0]   fall
);

  logic [IO_COUNT-1:0] in_m_q, in_s_q, in_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_m_q <= '0;
      in_s_q <= '0;
      in_d_q <= '0;
    end else begin
      in_m_q <= pin_in;
      in_s_q <= in_m_q;
      in_d_q <= filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [IO_COUNT-1:0]   flt_q, flt_d;
  logic [DEBOUNCE_W-1:0] cnt_q [IO_COUNT];
  logic [DEBOUNCE_W-1:0] cnt_d [IO_COUNT];

  // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
  always_comb begin
    flt_d = flt_q;
    for (int i = 0; i < IO_COUNT; i++) begin
      cnt_d[i] = '0;
      if (in_s_q[i] != flt_q[i]) begin
        if (cnt_q[i] == debounce) flt_d[i] = in_s_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flt_q <= '0;
      for (int i = 0; i < IO_COUNT; i++) cnt_q[i] <= '0;
    end else begin
      flt_q <= flt_d;
      cnt_q <= cnt_d;
    end
  end

  assign filt = flt_q;
`else
  logic unused_debounce;
  assign unused_debounce = ^debounce;
  assign filt = in_s_q;
`endif

  assign rise = filt & ~in_d_q;
  assign fall = ~filt & in_d_q;

endmodule

// File: rtl/gpio_irq_device.sv
// GPIO peripheral: direction/output registers with atomic set/clear/toggle, per-pin level/edge interrupts, W1C status.
// Build option GPIO_DEBOUNCE_EN adds a DEBOUNCE register at 0x2C and a debounce stage ahead of the interrupt logic.
module gpio_irq_device
  import gpio_pkg::*;
#(
  parameter logic [3:0]          ID         = 4'h0,
  parameter int                  IO_COUNT   = 16,
  parameter logic [IO_COUNT-1:0] OE_RESET   = {IO_COUNT{1'b0}},
  parameter int                  DEBOUNCE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                peripheralEnable,
  input  logic                peripheralBus_we,
  input  logic                peripheralBus_oe,
  output logic                peripheralBus_busy,
  input  logic [15:0]         peripheralBus_address,
  input  logic [3:0]          peripheralBus_byteSelect,
  output logic [31:0]         peripheralBus_dataRead,
  input  logic [31:0]         peripheralBus_dataWrite,
  output logic                requestOutput,
  input  logic [IO_COUNT-1:0] gpio_input,
  output logic [IO_COUNT-1:0] gpio_output,
  output logic [IO_COUNT-1:0] gpio_oe,
  output logic                gpio_irq
);

  logic [IO_COUNT-1:0] oe_q, oe_d, out_q, out_d, en_q, en_d;
  logic [IO_COUNT-1:0] irq_edge_q, irq_edge_d, pol_q, pol_d, both_q, both_d;
  logic [IO_COUNT-1:0] stat_q, stat_d, w1c, ev;
  logic [IO_COUNT-1:0] filt, rise, fall, wm, wv;
  logic                irq_q, irq_d;
  logic [DEBOUNCE_W-1:0] deb_val;
  logic                sel, wr, mapped;
  logic [11:0]         offset;
  logic [31:0]         mask32, wbits32, rd;

  assign sel     = peripheralEnable && (peripheralBus_address[15:12] == ID);
  assign wr      = sel && peripheralBus_we;
  assign offset  = {peripheralBus_address[11:2], 2'b00};
  assign mask32  = lane_mask(peripheralBus_byteSelect);
  assign wbits32 = peripheralBus_dataWrite & mask32;
  assign wm      = mask32[IO_COUNT-1:0];
  assign wv      = wbits32[IO_COUNT-1:0];

  logic unused_ok;
  assign unused_ok = ^{peripheralBus_address[1:0], wbits32, mask32};

`ifdef GPIO_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] deb_q, deb_d;
  assign deb_val = deb_q;
`else
  assign deb_val = '0;
`endif

  gpio_pin_filter #(
    .IO_COUNT   (IO_COUNT),
    .DEBOUNCE_W (DEBOUNCE_W)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .pin_in   (gpio_input),
    .debounce (deb_val),
    .filt     (filt),
    .rise     (rise),
    .fall     (fall)
  );

  // Edge mode fires on any change when BOTH is set, otherwise only on the change landing at POL.
  assign ev = (~irq_edge_q & ~(filt ^ pol_q))
            | (irq_edge_q & (rise | fall) & (both_q | ~(filt ^ pol_q)));

  always_comb begin
    oe_d       = oe_q;
    out_d      = out_q;
    en_d       = en_q;
    irq_edge_d = irq_edge_q;
    pol_d      = pol_q;
    both_d     = both_q;
    w1c        = '0;
`ifdef GPIO_DEBOUNCE_EN
    deb_d      = deb_q;
`endif
    if (wr) begin
      case (offset)
        OFF_OE:       oe_d       = (oe_q & ~wm) | wv;
        OFF_OUT:      out_d      = (out_q & ~wm) | wv;
        OFF_OUT_SET:  out_d      = out_q | wv;
        OFF_OUT_CLR:  out_d      = out_q & ~wv;
        OFF_OUT_TGL:  out_d      = out_q ^ wv;
        OFF_IRQ_EN:   en_d       = (en_q & ~wm) | wv;
        OFF_IRQ_EDGE: irq_edge_d = (irq_edge_q & ~wm) | wv;
        OFF_IRQ_POL:  pol_d      = (pol_q & ~wm) | wv;
        OFF_IRQ_BOTH: both_d     = (both_q & ~wm) | wv;
        OFF_IRQ_STAT: w1c        = wv;
`ifdef GPIO_DEBOUNCE_EN
        OFF_DEBOUNCE: deb_d      = (deb_q & ~mask32[DEBOUNCE_W-1:0]) | wbits32[DEBOUNCE_W-1:0];
`endif
        default: ;
      endcase
    end
    // A new event in the same cycle as a W1C keeps the bit set.
    stat_d = (stat_q & ~w1c) | (ev & en_q);
    irq_d  = |(stat_q & en_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q       <= OE_RESET;
      out_q      <= '0;
      en_q       <= '0;
      irq_edge_q <= '0;
      pol_q      <= '0;
      both_q     <= '0;
      stat_q     <= '0;
      irq_q      <= 1'b0;
`ifdef GPIO_DEBOUNCE_EN
      deb_q      <= '0;
`endif
    end else begin
      oe_q       <= oe_d;
      out_q      <= out_d;
      en_q       <= en_d;
      irq_edge_q <= irq_edge_d;
      pol_q      <= pol_d;
      both_q     <= both_d;
      stat_q     <= stat_d;
      irq_q      <= irq_d;
`ifdef GPIO_DEBOUNCE_EN
      deb_q      <= deb_d;
`endif
    end
  end

  always_comb begin
    rd     = '0;
    mapped = 1'b1;
    case (offset)
      OFF_OE:       rd[IO_COUNT-1:0] = oe_q;
      OFF_OUT, OFF_OUT_SET, OFF_OUT_CLR, OFF_OUT_TGL:
                    rd[IO_COUNT-1:0] = out_q;
      OFF_IN:       rd[IO_COUNT-1:0] = filt;
      OFF_IRQ_EN:   rd[IO_COUNT-1:0] = en_q;
      OFF_IRQ_EDGE: rd[IO_COUNT-1:0] = irq_edge_q;
      OFF_IRQ_POL:  rd[IO_COUNT-1:0] = pol_q;
      OFF_IRQ_BOTH: rd[IO_COUNT-1:0] = both_q;
      OFF_IRQ_STAT: rd[IO_COUNT-1:0] = stat_q;
`ifdef GPIO_DEBOUNCE_EN
      OFF_DEBOUNCE: rd[DEBOUNCE_W-1:0] = deb_q;
`endif
      default:      mapped = 1'b0;
    endcase
  end

  assign requestOutput          = sel && peripheralBus_oe && mapped;
  assign peripheralBus_dataRead = requestOutput ? rd : UNMAPPED_READ;
  assign peripheralBus_busy     = 1'b0;
  assign gpio_output            = out_q;
  assign gpio_oe                = oe_q;
  assign gpio_irq               = irq_q;

endmodule

// File: tb/tb_gpio_irq_device.sv
// Scoreboard bench for gpio_irq_device: stimulus pushes expected responses, a negedge monitor pops and compares.
// Also covers the debounce register and filter when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_irq_device;

  localparam logic [3:0]  ID_T  = 4'h3;
  localparam int          N     = 16;
  localparam logic [15:0] OE_RV = 16'hA5C3;
`ifdef GPIO_DEBOUNCE_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pe, we, oe, probe;
  logic [15:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [N-1:0] gpio_in;
  logic        busy, req, irq;
  logic [31:0] rdata;
  logic [N-1:0] gout, goe;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    bit          is_irq;
    logic        exp_req;
    logic [31:0] exp_data;
    logic        exp_irq;
  } exp_t;
  exp_t sb[$];

  gpio_irq_device #(
    .ID(ID_T), .IO_COUNT(N), .OE_RESET(OE_RV), .DEBOUNCE_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .peripheralEnable(pe), .peripheralBus_we(we), .peripheralBus_oe(oe),
    .peripheralBus_busy(busy), .peripheralBus_address(addr),
    .peripheralBus_byteSelect(be), .peripheralBus_dataRead(rdata),
    .peripheralBus_dataWrite(wdata), .requestOutput(req),
    .gpio_input(gpio_in), .gpio_output(gout), .gpio_oe(goe), .gpio_irq(irq)
  );

  always #5 clk = ~clk;

  // Monitor: one comparison per presented read or irq probe.
  always @(negedge clk) begin
    if ((pe && oe) || probe) begin
      if (sb.size() == 0) begin
        failures++;
        checks++;
        $display("FAIL scoreboard_underflow: unexpected output cycle at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (e.is_irq) begin
          if (irq !== e.exp_irq) begin
            failures++;
            $display("FAIL %s: gpio_irq got %0b expected %0b", e.name, irq, e.exp_irq);
          end else
            $display("ok   %s: gpio_irq=%0b", e.name, irq);
        end else begin
          if (req !== e.exp_req || rdata !== e.exp_data || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: req=%0b data=%08h busy=%0b expected req=%0b data=%08h busy=0",
                     e.name, req, rdata, busy, e.exp_req, e.exp_data);
          end else
            $display("ok   %s: req=%0b data=%08h", e.name, req, rdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] id, input logic [11:0] off,
                           input logic [31:0] d, input logic [3:0] lanes);
    pe = 1'b1; we = 1'b1; addr = {id, off}; wdata = d; be = lanes;
    step();
    pe = 1'b0; we = 1'b0; be = 4'h0;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] d);
    bus_write(ID_T, off, d, 4'hF);
  endtask

  task automatic bus_read(input logic [11:0] off, input logic exp_req,
                          input logic [31:0] exp_data, input string nm);
    exp_t e;
    e.name = nm; e.is_irq = 1'b0; e.exp_req = exp_req; e.exp_data = exp_data; e.exp_irq = 1'b0;
    sb.push_back(e);
    pe = 1'b1; oe = 1'b1; addr = {ID_T, off};
    step();
    pe = 1'b0; oe = 1'b0;
  endtask

  task automatic rd(input logic [11:0] off, input logic [31:0] exp_data, input string nm);
    bus_read(off, 1'b1, exp_data, nm);
  endtask

  task automatic probe_irq(input logic exp_irq, input string nm);
    exp_t e;
    e.name = nm; e.is_irq = 1'b1; e.exp_req = 1'b0; e.exp_data = '0; e.exp_irq = exp_irq;
    sb.push_back(e);
    probe = 1'b1;
    step();
    probe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pe = 0; we = 0; oe = 0; probe = 0;
    addr = '0; be = '0; wdata = '0; gpio_in = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state and unmapped decode
    rd(12'h000, {16'h0, OE_RV}, "reset_oe");
    rd(12'h004, 32'h0, "reset_out");
    rd(12'h028, 32'h0, "reset_stat");
    bus_read(12'h030, 1'b0, 32'hFFFF_FFFF, "unmapped_0x30");
`ifndef GPIO_DEBOUNCE_EN
    bus_read(12'h02C, 1'b0, 32'hFFFF_FFFF, "unmapped_0x2c");
`endif
    probe_irq(1'b0, "reset_irq");

    // Output register and atomic aliases
    wr(12'h004, 32'h00F0);
    wr(12'h008, 32'h0003);
    wr(12'h00C, 32'h0010);
    wr(12'h010, 32'h0101);
    rd(12'h004, 32'h01E2, "out_set_clr_tgl");
    rd(12'h008, 32'h01E2, "out_set_alias_read");
    bus_write(ID_T, 12'h004, 32'hFFFF, 4'b0001);
    rd(12'h004, 32'h01FF, "out_byte_lane");
    wr(12'h014, 32'hFFFF);
    rd(12'h014, 32'h0, "in_write_ignored");
    bus_write(4'h5, 12'h004, 32'h0, 4'hF);
    rd(12'h004, 32'h01FF, "wrong_id_write");
    wr(12'h000, 32'hFFFF_FFFF);
    rd(12'h000, 32'h0000_FFFF, "oe_upper_bits_ignored");

    // Rising edge on pin 0
    wr(12'h01C, 32'h1);
    wr(12'h020, 32'h1);
    wr(12'h018, 32'h1);
    gpio_in[0] = 1'b1;
    repeat (2 + XL) step();
    rd(12'h028, 32'h0, "edge_stat_before");
    rd(12'h028, 32'h1, "edge_stat_set");
    probe_irq(1'b1, "edge_irq_set");
    wr(12'h028, 32'h1);
    probe_irq(1'b1, "w1c_irq_lag");
    probe_irq(1'b0, "w1c_irq_cleared");
    rd(12'h028, 32'h0, "w1c_stat_cleared");
    gpio_in[0] = 1'b0;
    repeat (6) step();
    rd(12'h028, 32'h0, "falling_no_event");

    // Level-low on pin 3
    wr(12'h018, 32'h9);
    repeat (2) step();
    wr(12'h028, 32'h8);
    rd(12'h028, 32'h8, "level_resets_after_w1c");
    gpio_in[3] = 1'b1;
    repeat (5) step();
    wr(12'h028, 32'h8);
    rd(12'h028, 32'h0, "level_cleared");

    // Both-edge on pin 5
    wr(12'h01C, 32'h21);
    wr(12'h024, 32'h20);
    wr(12'h018, 32'h29);
    rd(12'h028, 32'h0, "both_idle");
    gpio_in[5] = 1'b1;
    repeat (3 + XL) step();
    rd(12'h028, 32'h20, "both_rise_event");
    gpio_in[5] = 1'b0;
    wr(12'h028, 32'h20);
    rd(12'h028, 32'h0, "both_cleared");
    repeat (1 + XL) step();
    rd(12'h028, 32'h20, "both_fall_event");
    wr(12'h028, 32'h20);
    rd(12'h028, 32'h0, "both_cleared_again");
    gpio_in[5] = 1'b1;
    repeat (2 + XL) step();
    wr(12'h028, 32'h20);
    rd(12'h028, 32'h20, "set_wins_over_w1c");

`ifdef GPIO_DEBOUNCE_EN
    // Debounce on pin 7
    wr(12'h028, 32'hFFFF);
    wr(12'h02C, 32'h4);
    rd(12'h02C, 32'h4, "debounce_reg");
    wr(12'h01C, 32'hA1);
    wr(12'h020, 32'h81);
    wr(12'h018, 32'hA9);
    gpio_in[7] = 1'b1;
    repeat (3) step();
    gpio_in[7] = 1'b0;
    repeat (10) step();
    rd(12'h014, 32'h28, "glitch_in_unchanged");
    rd(12'h028, 32'h0, "glitch_no_stat");
    gpio_in[7] = 1'b1;
    repeat (12) step();
    rd(12'h014, 32'hA8, "stable_in_set");
    rd(12'h028, 32'h80, "stable_edge_event");
    probe_irq(1'b1, "stable_irq");
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expected responses never presented", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
